// File: rtl/frame_sync_pkg.sv
// Shared definitions for the frame synchroniser.
//   state_e   : controller states (HUNT, LEN, PAYLOAD, CHECK)
//   PRE_A/B   : preamble pair bytes, 0x55 followed by 0xD5
//   len_legal : length-byte legality test against a maximum payload size
package frame_sync_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  localparam logic [7:0] PRE_A = 8'h55;
  localparam logic [7:0] PRE_B = 8'hD5;

  // A length of zero carries no payload and is treated as corrupt.
  function automatic logic len_legal(input logic [7:0] len, input int unsigned max_len);
    return (len != 8'd0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/preamble_match.sv
// Preamble pair counter.
// Counts consecutive 0x55,0xD5 byte pairs on the valid byte stream and
// raises a combinational hit on the byte that completes the HDR_PAIRS-th pair.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : received byte
//   din_vld    : din carries a byte this cycle (no back-pressure; idle cycles are ignored)
//   clear      : hold the counter empty (the controller is locked on a frame)
//   hit        : this byte completes the required number of pairs
module preamble_match
  import frame_sync_pkg::*;
#(
  parameter int HDR_PAIRS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  input  logic       clear,
  output logic       hit
);

  localparam int CW = (HDR_PAIRS > 1) ? $clog2(HDR_PAIRS) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;   // previous valid byte opened a pair with 0x55

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    hit    = 1'b0;
    if (clear) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (din_vld) begin
      if (pend_q && (din == PRE_B)) begin
        pend_d = 1'b0;
        if (cnt_q == CW'(HDR_PAIRS - 1)) begin
          // Completed the last pair; restart so the next hunt begins empty.
          hit   = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (din == PRE_A) begin
        // 0x55 where 0xD5 was expected breaks the run but opens a new pair.
        if (pend_q) cnt_d = '0;
        pend_d = 1'b1;
      end else begin
        cnt_d  = '0;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame synchroniser: hunts for a preamble of HDR_PAIRS 0x55,0xD5 pairs,
// then reads a length byte, forwards that many payload bytes and checks
// a trailing XOR checksum byte.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : received byte stream
//   din_vld    : din carries a byte this cycle; valid-only, no ready, idle
//                cycles advance nothing except the locked idle timer
//   dout       : payload byte (holds last value between strobes)
//   dout_vld   : one-cycle strobe per payload byte
//   dout_last  : final payload byte, only together with dout_vld
//   lock       : controller is in LEN, PAYLOAD or CHECK
//   frame_ok   : pulse, checksum matched
//   frame_err  : pulse, bad length, bad checksum or idle timeout
//   frame_cnt  : good-frame count, saturating
//   dbg_state  : current controller state (frame_sync_pkg::state_e encoding)
// All outputs come from registers loaded on the edge that samples the byte.
module frame_sync_ctrl
  import frame_sync_pkg::*;
#(
  parameter int HDR_PAIRS = 5,
  parameter int MAX_LEN   = 64,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_vld,
  output logic [7:0]  dout,
  output logic        dout_vld,
  output logic        dout_last,
  output logic        lock,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic [1:0]  dbg_state
);

  localparam int IW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    csum_q, csum_d;
  logic [IW-1:0] idle_q, idle_d;

  logic [7:0]    dout_q, dout_d;
  logic          dout_vld_q, dout_vld_d;
  logic          dout_last_q, dout_last_d;
  logic          lock_q, lock_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          pre_hit;
  logic          pre_clear;

  // Pair counting only runs while hunting; once locked it is held empty,
  // which also leaves it cleared on every return to HUNT.
  assign pre_clear = (state_q != ST_HUNT);

  preamble_match #(
    .HDR_PAIRS (HDR_PAIRS)
  ) u_preamble_match (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .din_vld (din_vld),
    .clear   (pre_clear),
    .hit     (pre_hit)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    csum_d      = csum_q;
    idle_d      = idle_q;
    dout_d      = dout_q;
    dout_vld_d  = 1'b0;
    dout_last_d = 1'b0;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;

    if (state_q == ST_HUNT) begin
      idle_d = '0;
      if (pre_hit) state_d = ST_LEN;
    end else if (!din_vld) begin
      // Locked and starved: abandon the frame after TIMEOUT idle cycles.
      if (idle_q == IW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = ST_HUNT;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end else begin
      idle_d = '0;
      case (state_q)
        ST_LEN: begin
          if (len_legal(din, MAX_LEN)) begin
            rem_d   = din;
            csum_d  = '0;
            state_d = ST_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
          dout_d     = din;
          dout_vld_d = 1'b1;
          csum_d     = csum_q ^ din;
          rem_d      = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            dout_last_d = 1'b1;
            state_d     = ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_d = ST_HUNT;
          if (din == csum_q) begin
            ok_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    lock_d = (state_d != ST_HUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      rem_q       <= '0;
      csum_q      <= '0;
      idle_q      <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
      lock_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      csum_q      <= csum_d;
      idle_q      <= idle_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      dout_last_q <= dout_last_d;
      lock_q      <= lock_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign dout_last = dout_last_q;
  assign lock      = lock_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign frame_cnt = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Self-checking bench for frame_sync_ctrl: directed frames followed by
// randomized streams, compared every cycle against a byte-level reference model.
module tb_frame_sync_ctrl;
  import frame_sync_pkg::*;

  localparam int HDR_PAIRS = 5;
  localparam int MAX_LEN   = 64;
  localparam int TIMEOUT   = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_vld = 1'b0;
  logic [7:0]  dout;
  logic        dout_vld, dout_last, lock, frame_ok, frame_err;
  logic [15:0] frame_cnt;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  frame_sync_ctrl #(
    .HDR_PAIRS (HDR_PAIRS),
    .MAX_LEN   (MAX_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_last (dout_last),
    .lock      (lock),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Byte-level view: after lock, one length byte, then L payload bytes and
  // one checksum byte ("left" counts payload plus checksum still to come).
  logic [7:0] exp_q[$];
  bit         m_locked, m_len_pend, m_pend55;
  int         m_pairs, m_left, m_idle, m_cnt;
  logic [7:0] m_sum;
  bit         e_vld, e_last, e_ok, e_err;

  task automatic model_reset();
    m_locked = 0; m_len_pend = 0; m_pend55 = 0;
    m_pairs = 0; m_left = 0; m_idle = 0; m_cnt = 0; m_sum = 8'h00;
    e_vld = 0; e_last = 0; e_ok = 0; e_err = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic vld, input logic [7:0] b);
    e_vld = 0; e_last = 0; e_ok = 0; e_err = 0;
    if (!m_locked) begin
      m_idle = 0;
      if (vld) begin
        if (m_pend55 && b == 8'hD5) begin
          m_pend55 = 0;
          m_pairs++;
          if (m_pairs == HDR_PAIRS) begin
            m_pairs = 0; m_locked = 1; m_len_pend = 1;
          end
        end else if (b == 8'h55) begin
          if (m_pend55) m_pairs = 0;
          m_pend55 = 1;
        end else begin
          m_pairs = 0; m_pend55 = 0;
        end
      end
    end else if (!vld) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        e_err = 1; m_locked = 0; m_len_pend = 0; m_idle = 0;
      end
    end else begin
      m_idle = 0;
      if (m_len_pend) begin
        m_len_pend = 0;
        if (b == 0 || int'(b) > MAX_LEN) begin
          e_err = 1; m_locked = 0;
        end else begin
          m_left = int'(b) + 1; m_sum = 8'h00;
        end
      end else if (m_left > 1) begin
        m_left--;
        e_vld = 1; e_last = (m_left == 1);
        m_sum = m_sum ^ b;
        exp_q.push_back(b);
      end else begin
        m_locked = 0;
        if (b == m_sum) begin
          e_ok = 1;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          e_err = 1;
        end
      end
    end
  endtask

  int ok_seen = 0;
  int err_seen = 0;

  task automatic check_outputs();
    chk("lock", 32'(lock), 32'(m_locked));
    chk("dout_vld", 32'(dout_vld), 32'(e_vld));
    chk("dout_last", 32'(dout_last), 32'(e_last));
    chk("frame_ok", 32'(frame_ok), 32'(e_ok));
    chk("frame_err", 32'(frame_err), 32'(e_err));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("ok_err_excl", 32'(frame_ok & frame_err), 32'd0);
    if (dout_vld && exp_q.size() > 0) chk("dout", 32'(dout), 32'(exp_q.pop_front()));
    if (frame_ok) ok_seen++;
    if (frame_err) err_seen++;
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input logic vld, input logic [7:0] b);
    din = b; din_vld = vld;
    @(posedge clk);
    model_step(vld, b);
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom_range(0, 255));
  endtask

  task automatic preamble(input int pairs);
    for (int i = 0; i < pairs; i++) begin send(PRE_A); send(PRE_B); end
  endtask

  task automatic maybe_gap();
    int unsigned r;
    r = $urandom_range(0, 59);
    if (r == 0) idle(TIMEOUT + 2);
    else if (r < 10) idle($urandom_range(1, 4));
  endtask

  task automatic send_g(input logic [7:0] b);
    maybe_gap();
    send(b);
  endtask

  task automatic rand_frame();
    int unsigned len;
    logic [7:0]  sum, b;
    int unsigned njunk;
    njunk = $urandom_range(0, 3);
    for (int i = 0; i < int'(njunk); i++) begin
      case ($urandom_range(0, 3))
        0: b = PRE_A;
        1: b = PRE_B;
        2: b = 8'h00;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_g(b);
    end
    for (int i = 0; i < HDR_PAIRS; i++) begin
      if ($urandom_range(0, 24) == 0) send_g(8'($urandom_range(0, 255)));
      else send_g(PRE_A);
      send_g(PRE_B);
    end
    len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(1, MAX_LEN);
    send_g(8'(len));
    sum = 8'h00;
    for (int i = 0; i < int'(len) && i < 80; i++) begin
      b = 8'($urandom_range(0, 255));
      sum = sum ^ b;
      send_g(b);
    end
    if ($urandom_range(0, 3) == 0) send_g(sum ^ 8'($urandom_range(1, 255)));
    else send_g(sum);
  endtask

  // ---------------- stimulus ----------------
  int ok0, err0;
  logic [15:0] cnt0;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_vld", 32'(dout_vld), 32'd0);
    chk("rst_ok", 32'(frame_ok), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_HUNT));
    rst_n = 1'b1;

    // Good frame 11,22,33 with checksum 00.
    idle(10);
    preamble(5); send(8'h03); send(8'h11); send(8'h22);
    send(8'h33);
    chk("last_on_33", 32'(dout_last), 32'd1);
    send(8'h00);
    chk("ok_pulse", 32'(frame_ok), 32'd1);
    chk("cnt_one", 32'(frame_cnt), 32'd1);

    // Short preamble never locks.
    preamble(2); send(8'h00); send(8'h00); send(8'h00);
    chk("short_pre_lock", 32'(lock), 32'd0);

    // Near-miss pairs, then a real preamble.
    for (int i = 0; i < 3; i++) begin send(8'h56); send(8'hD6); end
    chk("nearmiss_lock", 32'(lock), 32'd0);
    preamble(5);
    chk("lock_after_pre", 32'(lock), 32'd1);
    send(8'h01); send(8'h5A); send(8'h5A);

    // Illegal lengths.
    preamble(5); send(8'h00);
    chk("len0_err", 32'(frame_err), 32'd1);
    chk("len0_unlock", 32'(lock), 32'd0);
    preamble(5); send(8'h50);
    chk("len50_err", 32'(frame_err), 32'd1);
    chk("len50_unlock", 32'(lock), 32'd0);

    // Wrong checksum leaves the counter alone.
    cnt0 = frame_cnt;
    preamble(5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'hFF);
    chk("badcs_err", 32'(frame_err), 32'd1);
    chk("badcs_cnt", 32'(frame_cnt), 32'(cnt0));

    // Idle timeout mid-payload.
    preamble(5); send(8'h02); send(8'hA5);
    idle(TIMEOUT - 1);
    chk("timeout_early_lock", 32'(lock), 32'd1);
    idle(1);
    chk("timeout_err", 32'(frame_err), 32'd1);
    chk("timeout_unlock", 32'(lock), 32'd0);

    // Asynchronous reset mid-payload: immediate clear, no error pulse.
    preamble(5); send(8'h04); send(8'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_lock", 32'(lock), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_vld", 32'(dout_vld), 32'd0);
    chk("mid_rst_err", 32'(frame_err), 32'd0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_HUNT));
    model_reset();
    @(posedge clk); #1;
    chk("held_rst_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    send(8'h88); send(8'h99);

    // Randomized streams.
    ok0 = ok_seen; err0 = err_seen;
    for (int f = 0; f < 60; f++) rand_frame();
    idle(TIMEOUT + 2);
    chk("rand_ok_count", 32'(frame_cnt), 32'(m_cnt));
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_activity", 32'((ok_seen - ok0) > 0 && (err_seen - err0) > 0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global bound in case a driver ever stalls.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
